// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the arbiter state encoding,
// the default byte width, and the clock/baud defaults also used by the TX/RX cores.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int CLK_HZ      = 50_000_000;
   localparam int BAUD        = 115_200;

   // ARB picks an owner, GRANT waits for its byte, LAUNCH emits the start
   // pulse, and DRAIN waits for the TX core to finish the frame.
   typedef enum logic [1:0] {
      ARB    = 2'd0,
      GRANT  = 2'd1,
      LAUNCH = 2'd2,
      DRAIN  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is doubled and shifted
// down by the pointer, so the lowest set bit of the window is the first
// requester at or above the pointer. That bit is isolated and then rotated
// back to its original position.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic             any
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   win_rot;

   // rotate requests so the pointer lands on bit 0, keep the lowest set bit, rotate back
   always_comb begin
      req_dbl = {req, req};
      req_rot = N'(req_dbl >> ptr);
      win_rot = req_rot & (~req_rot + N'(1));
      win     = N'(({win_rot, win_rot} << ptr) >> N);
      any     = |req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between several byte
// producers. An owner keeps the line until it sends a byte flagged last, or
// until it stalls long enough for the timeout to reclaim the grant. The
// arbiter also sequences the transmitter's start/busy handshake.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = UART_DATA_W,
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        grant,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    err_timeout
);

   localparam int                PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(N_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               last_q, last_d;
   logic               err_timeout_q, err_timeout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [N_REQ-1:0]   pick_win;
   logic               pick_any;
   logic [DATA_W-1:0]  owner_data;
   logic               owner_last;
   logic [PTR_W-1:0]   owner_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic               accept;

   rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .win (pick_win),
      .any (pick_any)
   );

   // select the owner's byte, last flag and index, and the pointer used on release
   always_comb begin
      owner_data = '0;
      owner_last = 1'b0;
      owner_idx  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            owner_data = owner_data | req_data[i*DATA_W +: DATA_W];
            owner_last = owner_last | req_last[i];
            owner_idx  = owner_idx | PTR_W'(i);
         end
      end
      next_ptr = (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);
   end

   // only the owner sees ready, and only while waiting for its byte
   always_comb begin
      req_ready = (state_q == GRANT) ? grant_q : '0;
      accept    = |(req_valid & req_ready);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; an accept on the timeout cycle takes priority over the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (pick_any) state_d = GRANT;
         GRANT: begin
            if (accept)                 state_d = LAUNCH;
            else if (cnt_q == CNT_LAST) state_d = ARB;
         end
         LAUNCH:  state_d = DRAIN;
         DRAIN:   if (!tx_busy) state_d = last_q ? ARB : GRANT;
         default: state_d = ARB;
      endcase
   end

   // datapath and output next values: grant capture, byte launch, timeout and release
   always_comb begin
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      last_d        = last_q;
      err_timeout_d = 1'b0;
      cnt_d         = cnt_q;
      case (state_q)
         ARB: begin
            grant_d = pick_win;
         end
         GRANT: begin
            if (accept) begin
               tx_data_d  = owner_data;
               last_d     = owner_last;
               tx_start_d = 1'b1;
               cnt_d      = '0;
            end else if (cnt_q == CNT_LAST) begin
               err_timeout_d = 1'b1;
               grant_d       = '0;
               rr_ptr_d      = next_ptr;
               cnt_d         = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (!tx_busy && last_q) begin
               grant_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: begin
         end
      endcase
   end

   // datapath registers; reset also cuts any start pulse in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         last_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         last_q        <= last_d;
         err_timeout_q <= err_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign grant       = grant_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters and a short timeout.
// Each requester replays a small list of bytes, optionally holding a byte back
// for a number of ready cycles. A TX core model holds busy for 10 cycles per
// byte. Every start pulse is logged and compared with hand-computed sequences.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    grant;
   logic [DW-1:0]   tx_data;
   logic            tx_start;
   logic            tx_busy;
   logic            err_timeout;

   int checks = 0;
   int errors = 0;

   // requester byte lists
   logic [7:0] mem_data [N][8];
   logic       mem_last [N][8];
   int         mem_hold [N][8];
   int         len  [N];
   int         pos  [N];
   int         hold [N];

   // TX core model and observation state
   int   busy_cnt;
   bit   pending;
   int   cycle;
   int   fall_cycle;
   int   run;
   int   err_cnt;

   // start-pulse log and expected sequences
   logic [7:0] log_data  [32];
   logic [3:0] log_grant [32];
   int         log_gap   [32];
   int         log_n;
   logic [7:0] exp_data  [8];
   logic [3:0] exp_grant [8];

   uart_tx_arbiter #(
      .N_REQ       (N),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .err_timeout (err_timeout)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // hard stop in case the directed sequence never completes
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // drive each requester from the head of its byte list
   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         if (pos[i] < len[i]) begin
            req_valid[i]          = (hold[i] == 0);
            req_data[i*DW +: DW]  = mem_data[i][pos[i]];
            req_last[i]           = mem_last[i][pos[i]];
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*DW +: DW]  = '0;
            req_last[i]           = 1'b0;
         end
      end
   endtask

   task automatic addByte(input int i, input logic [7:0] d, input logic l, input int h);
      mem_data[i][len[i]] = d;
      mem_last[i][len[i]] = l;
      mem_hold[i][len[i]] = h;
      if (pos[i] == len[i]) hold[i] = h;
      len[i]++;
   endtask

   // one clock: record handshakes, advance requesters and the TX model, observe outputs
   task automatic tick();
      logic [N-1:0] rdy;
      logic [N-1:0] acc;
      bit           busy_prev;
      rdy = req_ready;
      acc = req_valid & req_ready;
      if (acc != 0)      run = 0;
      else if (rdy != 0) run++;
      else               run = 0;
      @(posedge clk);
      #1;
      cycle++;
      for (int i = 0; i < N; i++) begin
         if (acc[i] === 1'b1) begin
            pos[i]++;
            hold[i] = (pos[i] < len[i]) ? mem_hold[i][pos[i]] : 0;
         end else if (rdy[i] === 1'b1 && hold[i] > 0) begin
            hold[i]--;
         end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (pending) begin
         busy_cnt = 10;
         pending  = 1'b0;
      end
      busy_prev = tx_busy;
      tx_busy   = (busy_cnt > 0);
      if (busy_prev && !tx_busy) fall_cycle = cycle;
      if (tx_start === 1'b1) begin
         checkOutput("start_while_busy", 32'(tx_busy), 32'd0);
         pending = 1'b1;
         if (log_n < 32) begin
            log_data[log_n]  = tx_data;
            log_grant[log_n] = grant;
            log_gap[log_n]   = cycle - fall_cycle;
            log_n++;
         end
      end
      if (err_timeout === 1'b1) begin
         err_cnt++;
         checkOutput("err_stall_len", 32'(run), 32'(TO));
         checkOutput("err_grant", 32'(grant), 32'd0);
      end
      checkOutput("ready_nonowner", 32'(req_ready & ~grant), 32'd0);
      applyStimulus();
   endtask

   task automatic runUntilIdle(input string tag, input int max_cyc);
      bit done;
      done = 1'b0;
      for (int k = 0; k < max_cyc && !done; k++) begin
         tick();
         done = 1'b1;
         for (int i = 0; i < N; i++) if (pos[i] < len[i]) done = 1'b0;
         if (grant != 0 || tx_busy || busy_cnt != 0 || pending) done = 1'b0;
      end
      checkOutput($sformatf("%s_idle", tag), 32'(done), 32'd1);
   endtask

   task automatic compareLog(input string tag, input int n);
      checkOutput($sformatf("%s_count", tag), 32'(log_n), 32'(n));
      for (int k = 0; k < n; k++) begin
         checkOutput($sformatf("%s_data%0d", tag, k), 32'(log_data[k]), 32'(exp_data[k]));
         checkOutput($sformatf("%s_grant%0d", tag, k), 32'(log_grant[k]), 32'(exp_grant[k]));
      end
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      tx_busy = 1'b0;
      req_valid = '0;
      req_data = '0;
      req_last = '0;
      busy_cnt = 0;
      pending = 1'b0;
      cycle = 0;
      fall_cycle = 0;
      run = 0;
      err_cnt = 0;
      log_n = 0;
      for (int i = 0; i < N; i++) begin
         len[i] = 0;
         pos[i] = 0;
         hold[i] = 0;
      end

      // reset with every requester valid, then one-byte packets in round-robin order
      $display("[TB] reset and round-robin");
      addByte(0, 8'h41, 1'b1, 0);
      addByte(0, 8'h45, 1'b1, 0);
      addByte(1, 8'h42, 1'b1, 0);
      addByte(2, 8'h43, 1'b1, 0);
      addByte(3, 8'h44, 1'b1, 0);
      applyStimulus();
      #1;
      repeat (3) tick();
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_err", 32'(err_timeout), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      log_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("first_grant", 32'(grant), 32'h1);
      checkOutput("first_ready", 32'(req_ready), 32'h1);
      checkOutput("first_no_start", 32'(tx_start), 32'd0);
      tick();
      checkOutput("first_start", 32'(tx_start), 32'd1);
      checkOutput("first_data", 32'(tx_data), 32'h41);
      checkOutput("launch_ready", 32'(req_ready), 32'd0);
      tick();
      checkOutput("start_single", 32'(tx_start), 32'd0);
      runUntilIdle("rr", 300);
      exp_data[0] = 8'h41; exp_grant[0] = 4'b0001;
      exp_data[1] = 8'h42; exp_grant[1] = 4'b0010;
      exp_data[2] = 8'h43; exp_grant[2] = 4'b0100;
      exp_data[3] = 8'h44; exp_grant[3] = 4'b1000;
      exp_data[4] = 8'h45; exp_grant[4] = 4'b0001;
      compareLog("rr", 5);

      // three-byte packet from requester 1 must not interleave with requester 2
      $display("[TB] packet atomicity");
      log_n = 0;
      addByte(1, 8'h10, 1'b0, 0);
      addByte(1, 8'h11, 1'b0, 0);
      addByte(1, 8'h12, 1'b1, 0);
      addByte(2, 8'h20, 1'b1, 0);
      applyStimulus();
      runUntilIdle("pkt", 300);
      exp_data[0] = 8'h10; exp_grant[0] = 4'b0010;
      exp_data[1] = 8'h11; exp_grant[1] = 4'b0010;
      exp_data[2] = 8'h12; exp_grant[2] = 4'b0010;
      exp_data[3] = 8'h20; exp_grant[3] = 4'b0100;
      compareLog("pkt", 4);
      checkOutput("gap_byte1", 32'(log_gap[1]), 32'd2);
      checkOutput("gap_byte2", 32'(log_gap[2]), 32'd2);
      checkOutput("gap_next_pkt", 32'(log_gap[3]), 32'd3);
      checkOutput("no_err_yet", 32'(err_cnt), 32'd0);

      // requester 3 stalls for the full timeout; requester 0 accepts on the last allowed cycle
      $display("[TB] timeout");
      log_n = 0;
      err_cnt = 0;
      addByte(3, 8'h30, 1'b0, 0);
      addByte(3, 8'h31, 1'b1, TO);
      addByte(0, 8'h50, 1'b0, 0);
      addByte(0, 8'h51, 1'b1, TO - 1);
      applyStimulus();
      runUntilIdle("tmo", 500);
      checkOutput("tmo_err_count", 32'(err_cnt), 32'd1);
      exp_data[0] = 8'h30; exp_grant[0] = 4'b1000;
      exp_data[1] = 8'h50; exp_grant[1] = 4'b0001;
      exp_data[2] = 8'h51; exp_grant[2] = 4'b0001;
      exp_data[3] = 8'h31; exp_grant[3] = 4'b1000;
      compareLog("tmo", 4);

      // reset during DRAIN, then arbitration restarts from requester 0
      $display("[TB] reset in drain");
      addByte(1, 8'h61, 1'b1, 0);
      applyStimulus();
      runUntilIdle("pre_rst", 100);
      addByte(2, 8'h60, 1'b1, 0);
      applyStimulus();
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (tx_start === 1'b1) seen = 1'b1;
      end
      checkOutput("drain_start_seen", 32'(seen), 32'd1);
      tick();
      tick();
      checkOutput("drain_grant", 32'(grant), 32'b0100);
      checkOutput("drain_tx_data", 32'(tx_data), 32'h60);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_grant", 32'(grant), 32'd0);
      checkOutput("async_ready", 32'(req_ready), 32'd0);
      checkOutput("async_tx_start", 32'(tx_start), 32'd0);
      checkOutput("async_tx_data", 32'(tx_data), 32'd0);
      checkOutput("async_err", 32'(err_timeout), 32'd0);
      busy_cnt = 0;
      pending = 1'b0;
      tx_busy = 1'b0;
      addByte(0, 8'h70, 1'b1, 0);
      addByte(3, 8'h73, 1'b1, 0);
      applyStimulus();
      tick();
      tick();
      checkOutput("rst_hold_grant", 32'(grant), 32'd0);
      log_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("restart_grant", 32'(grant), 32'b0001);
      runUntilIdle("restart", 200);
      exp_data[0] = 8'h70; exp_grant[0] = 4'b0001;
      exp_data[1] = 8'h73; exp_grant[1] = 4'b1000;
      compareLog("restart", 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
